// File: rtl/mixer_multi_ramp_if.sv
// Bus between the serial front end and the mixer: serial/slot clocks, serial data,
// per-channel gain controls and the mixed serial/parallel results.
interface mixer_multi_ramp_if #(
  parameter int N_CH   = 4,
  parameter int W_GAIN = 8,
  parameter int W_OUT  = 24
);
  logic                     bclk;
  logic                     lrclk;
  logic [N_CH-1:0]          in;
  logic [N_CH*W_GAIN-1:0]   level;
  logic [N_CH-1:0]          mute;
  logic                     out;
  logic [W_OUT-1:0]         out_p;
  logic                     out_valid;
  logic                     sat;

  modport master (
    output bclk, lrclk, in, level, mute,
    input  out, out_p, out_valid, sat
  );

  modport slave (
    input  bclk, lrclk, in, level, mute,
    output out, out_p, out_valid, sat
  );
endinterface

// File: rtl/mixer_multi_ramp.sv
// Bit-serial N-channel mixer: captures one word per channel per slot, multiplies by a
// ramped per-channel gain, sums, saturates, and emits the result serially and in parallel.
module mixer_multi_ramp #(
  parameter int N_CH      = 4,
  parameter int W_SAMPLE  = 24,
  parameter int W_GAIN    = 8,
  parameter int W_OUT     = 24,
  parameter int RAMP_STEP = 1
) (
  input logic              clk,
  input logic              rst_n,
  mixer_multi_ramp_if.slave bus
);

  localparam int W_CNT = $clog2(W_SAMPLE + 1);
  localparam int W_ACC = W_SAMPLE + W_GAIN + $clog2(N_CH) + 1;
  localparam int W_CH  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int W_PRD = W_SAMPLE + W_GAIN + 1;
  localparam logic [W_CNT-1:0]  CNT_FULL = W_CNT'(W_SAMPLE);
  localparam logic [W_CH-1:0]   LAST_CH  = W_CH'(N_CH - 1);
  localparam logic [W_GAIN:0]   STEP     = (W_GAIN + 1)'(RAMP_STEP);

  typedef enum logic [1:0] {IDLE, MAC, SAT, DONE} state_t;

  state_t state_reg, state_next;
  logic   start, mac_en;

  logic bclk_q, lrclk_q;
  logic bclk_rise, bclk_fall, lr_edge;
  logic pending_reg;

  logic [N_CH*W_SAMPLE-1:0] sample_flat;
  logic [N_CH*W_GAIN-1:0]   gain_flat;
  logic [W_SAMPLE-1:0]      cur_sample;
  logic [W_GAIN-1:0]        cur_gain;
  logic signed [W_PRD-1:0]  prod;

  logic [W_CH-1:0]          ch_reg;
  logic signed [W_ACC-1:0]  acc_reg;
  logic signed [W_ACC-1:0]  shifted;
  logic [W_ACC-W_OUT:0]     hi_bits;
  logic                     over;
  logic [W_OUT-1:0]         clip_val;
  logic [W_OUT-1:0]         res_reg;
  logic                     res_sat_reg;

  logic [W_OUT-1:0]         out_sr_reg;
  logic [W_OUT-1:0]         out_p_reg;
  logic                     out_valid_reg;
  logic                     sat_reg;

  assign bclk_rise = bus.bclk & ~bclk_q;
  assign bclk_fall = ~bus.bclk & bclk_q;
  assign lr_edge   = bus.lrclk ^ lrclk_q;

  always_ff @(posedge clk) begin
    bclk_q  <= bus.bclk;
    lrclk_q <= bus.lrclk;
  end

  // Per-channel capture, word latch, MAC operand snapshot and gain ramp
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [W_SAMPLE-1:0] sr_reg, word_reg, sample_reg, just_word;
      logic [W_CNT-1:0]    cnt_reg;
      logic [W_GAIN-1:0]   gain_reg, tgt, gain_next;
      logic [W_GAIN:0]     diff, delta;
      logic                up;

      assign just_word = sr_reg << (CNT_FULL - cnt_reg);

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sr_reg     <= '0;
          cnt_reg    <= '0;
          word_reg   <= '0;
          sample_reg <= '0;
        end else begin
          if (lr_edge) begin
            sr_reg   <= '0;
            cnt_reg  <= '0;
            word_reg <= just_word;
          end else if (bclk_rise && (cnt_reg < CNT_FULL)) begin
            sr_reg  <= {sr_reg[W_SAMPLE-2:0], bus.in[gi]};
            cnt_reg <= cnt_reg + 1'b1;
          end
          // Private copy so a slot edge mid-computation cannot disturb the MAC
          if (start) sample_reg <= lr_edge ? just_word : word_reg;
        end
      end

      assign tgt       = bus.mute[gi] ? '0 : bus.level[gi*W_GAIN +: W_GAIN];
      assign up        = (tgt > gain_reg);
      assign diff      = up ? ({1'b0, tgt} - {1'b0, gain_reg}) : ({1'b0, gain_reg} - {1'b0, tgt});
      assign delta     = (diff > STEP) ? STEP : diff;
      assign gain_next = up ? (gain_reg + delta[W_GAIN-1:0]) : (gain_reg - delta[W_GAIN-1:0]);

      always_ff @(posedge clk) begin
        if (!rst_n)               gain_reg <= '0;
        else if (state_reg == DONE) gain_reg <= gain_next;
      end

      assign sample_flat[gi*W_SAMPLE +: W_SAMPLE] = sample_reg;
      assign gain_flat[gi*W_GAIN +: W_GAIN]       = gain_reg;
    end
  endgenerate

  always_comb begin
    cur_sample = '0;
    cur_gain   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_reg == W_CH'(i)) begin
        cur_sample = sample_flat[i*W_SAMPLE +: W_SAMPLE];
        cur_gain   = gain_flat[i*W_GAIN +: W_GAIN];
      end
    end
  end

  assign prod = $signed(cur_sample) * $signed({1'b0, cur_gain});

  // Clip when the bits above the output sign bit are not a pure sign extension
  assign shifted  = acc_reg >>> (W_GAIN - 1);
  assign hi_bits  = shifted[W_ACC-1:W_OUT-1];
  assign over     = ~((&hi_bits) | (~|hi_bits));
  assign clip_val = !over ? shifted[W_OUT-1:0] :
                    shifted[W_ACC-1] ? {1'b1, {(W_OUT-1){1'b0}}} : {1'b0, {(W_OUT-1){1'b1}}};

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    mac_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (lr_edge || pending_reg) begin
          start      = 1'b1;
          state_next = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (ch_reg == LAST_CH) state_next = SAT;
      end
      SAT:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      pending_reg   <= 1'b0;
      ch_reg        <= '0;
      acc_reg       <= '0;
      res_reg       <= '0;
      res_sat_reg   <= 1'b0;
      out_sr_reg    <= '0;
      out_p_reg     <= '0;
      out_valid_reg <= 1'b0;
      sat_reg       <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= start ? 1'b0 : (pending_reg | (lr_edge && (state_reg != IDLE)));
      if (start) begin
        acc_reg <= '0;
        ch_reg  <= '0;
      end else if (mac_en) begin
        acc_reg <= acc_reg + W_ACC'(prod);
        ch_reg  <= ch_reg + 1'b1;
      end
      if (state_reg == SAT) begin
        res_reg     <= clip_val;
        res_sat_reg <= over;
      end
      out_valid_reg <= (state_reg == DONE);
      if (state_reg == DONE) begin
        out_p_reg  <= res_reg;
        sat_reg    <= res_sat_reg;
        out_sr_reg <= res_reg;
      end else if (bclk_fall) begin
        out_sr_reg <= out_sr_reg << 1;
      end
    end
  end

  assign bus.out       = out_sr_reg[W_OUT-1];
  assign bus.out_p     = out_p_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.sat       = sat_reg;

endmodule

// File: tb/tb_mixer_multi_ramp.sv
// Three mixers with ramp steps 255, 1 and 4 share one serial stimulus; a reference
// model predicts every slot result into a queue that is checked at each out_valid.
module tb_mixer_multi_ramp;
  localparam int N_CH = 4;
  localparam int W_SAMPLE = 24;
  localparam int W_GAIN = 8;
  localparam int W_OUT = 24;
  localparam int N_DUT = 3;
  localparam int STEPS [N_DUT] = '{255, 1, 4};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bclk = 1'b0;
  logic lrclk = 1'b0;
  logic [N_CH-1:0] in_bits = '0;
  logic [7:0] lvl [N_DUT][N_CH];
  logic       mt  [N_DUT][N_CH];

  logic [N_DUT-1:0] out_w, valid_w, sat_w;
  logic [23:0]      outp_w [N_DUT];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
      mixer_multi_ramp_if #(.N_CH(N_CH), .W_GAIN(W_GAIN), .W_OUT(W_OUT)) bus ();
      assign bus.bclk  = bclk;
      assign bus.lrclk = lrclk;
      assign bus.in    = in_bits;
      for (genvar gj = 0; gj < N_CH; gj++) begin : g_ctl
        assign bus.level[gj*W_GAIN +: W_GAIN] = lvl[gi][gj];
        assign bus.mute[gj] = mt[gi][gj];
      end
      mixer_multi_ramp #(
        .N_CH(N_CH), .W_SAMPLE(W_SAMPLE), .W_GAIN(W_GAIN), .W_OUT(W_OUT),
        .RAMP_STEP(STEPS[gi])
      ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
      );
      assign out_w[gi]   = bus.out;
      assign valid_w[gi] = bus.out_valid;
      assign sat_w[gi]   = bus.sat;
      assign outp_w[gi]  = bus.out_p;
    end
  endgenerate

  int n_cmp = 0;
  int n_bad = 0;
  logic [74:0] sb_q [$];
  logic [74:0] sb_e;
  logic [23:0] slot_word [N_CH];
  int          mg [N_DUT][N_CH];
  logic [23:0] last_outp [N_DUT];
  logic        last_sat [N_DUT];
  logic [23:0] tx_cap [N_DUT];

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && (valid_w != '0)) begin
      $display("slot result: out_p %06h/%06h/%06h sat %b", outp_w[0], outp_w[1], outp_w[2], sat_w);
      if (sb_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_valid: got valid=%b, required no result", valid_w);
      end else begin
        sb_e = sb_q.pop_front();
        for (int d = 0; d < N_DUT; d++) begin
          n_cmp++;
          if (!valid_w[d] || {sat_w[d], outp_w[d]} !== sb_e[d*25 +: 25]) begin
            n_bad++;
            $display("FAIL scoreboard dut%0d: got valid=%b sat=%b out_p=%06h, required valid=1 sat=%b out_p=%06h",
                     d, valid_w[d], sat_w[d], outp_w[d], sb_e[d*25+24], sb_e[d*25 +: 24]);
          end
          last_outp[d] = outp_w[d];
          last_sat[d]  = sat_w[d];
        end
      end
    end
  end

  function automatic logic [24:0] model_out(int d, int nbits);
    longint acc = 0;
    longint r;
    logic [23:0] mask, wm;
    mask = 24'hFFFFFF << (24 - nbits);
    for (int ch = 0; ch < N_CH; ch++) begin
      wm = slot_word[ch] & mask;
      acc += longint'($signed(wm)) * longint'(mg[d][ch]);
    end
    r = acc >>> 7;
    if (r > 64'sd8388607)  return {1'b1, 24'h7FFFFF};
    if (r < -64'sd8388608) return {1'b1, 24'h800000};
    return {1'b0, r[23:0]};
  endfunction

  task automatic set_words(input logic [23:0] w0, w1, w2, w3);
    slot_word[0] = w0; slot_word[1] = w1; slot_word[2] = w2; slot_word[3] = w3;
  endtask

  task automatic send_bits(input int nbits);
    for (int b = 0; b < nbits; b++) begin
      for (int ch = 0; ch < N_CH; ch++) in_bits[ch] = slot_word[ch][23-b];
      repeat (3) @(negedge clk);
      for (int d = 0; d < N_DUT; d++) tx_cap[d] = {tx_cap[d][22:0], out_w[d]};
      @(negedge clk);
      bclk = 1'b1;
      repeat (4) @(negedge clk);
      bclk = 1'b0;
    end
  endtask

  task automatic end_slot(input int nbits);
    int tgt;
    @(negedge clk);
    lrclk = ~lrclk;
    sb_q.push_back({model_out(2, nbits), model_out(1, nbits), model_out(0, nbits)});
    repeat (8) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL result_latency: got %0d results still pending 8 clk after slot edge, required 0", sb_q.size());
      sb_q.delete();
    end
    for (int d = 0; d < N_DUT; d++) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        tgt = mt[d][ch] ? 0 : int'(lvl[d][ch]);
        if (tgt > mg[d][ch]) mg[d][ch] += ((tgt - mg[d][ch]) < STEPS[d]) ? (tgt - mg[d][ch]) : STEPS[d];
        else                 mg[d][ch] -= ((mg[d][ch] - tgt) < STEPS[d]) ? (mg[d][ch] - tgt) : STEPS[d];
      end
    end
  endtask

  task automatic run_slot(input int nbits);
    send_bits(nbits);
    end_slot(nbits);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int d = 0; d < N_DUT; d++) begin
      n_cmp += 4;
      if (out_w[d] !== 1'b0)    begin n_bad++; $display("FAIL reset_out dut%0d: got %b, required 0", d, out_w[d]); end
      if (valid_w[d] !== 1'b0)  begin n_bad++; $display("FAIL reset_valid dut%0d: got %b, required 0", d, valid_w[d]); end
      if (sat_w[d] !== 1'b0)    begin n_bad++; $display("FAIL reset_sat dut%0d: got %b, required 0", d, sat_w[d]); end
      if (outp_w[d] !== 24'h0)  begin n_bad++; $display("FAIL reset_out_p dut%0d: got %06h, required 000000", d, outp_w[d]); end
      for (int ch = 0; ch < N_CH; ch++) mg[d][ch] = 0;
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_unity();
    logic [23:0] exp_v;
    for (int d = 0; d < N_DUT; d++) lvl[d][0] = 8'd128;
    set_words(24'h100000, 24'h0, 24'h0, 24'h0);
    for (int k = 1; k <= 3; k++) begin
      run_slot(24);
      exp_v = (k == 1) ? 24'h0 : 24'h100000;
      n_cmp++;
      if (last_outp[0] !== exp_v || last_sat[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL unity_slot%0d: got %06h sat=%b, required %06h sat=0", k, last_outp[0], last_sat[0], exp_v);
      end
    end
  endtask

  task automatic test_ramp_up();
    logic [23:0] prev, exp_v;
    prev = last_outp[1];
    for (int k = 4; k <= 131; k++) begin
      run_slot(24);
      exp_v = 24'(((k - 1) < 128 ? (k - 1) : 128) * 32'h2000);
      n_cmp += 2;
      if (last_outp[1] !== exp_v) begin
        n_bad++;
        $display("FAIL ramp_up_slot%0d: got %06h, required %06h", k, last_outp[1], exp_v);
      end
      if (last_outp[1] < prev) begin
        n_bad++;
        $display("FAIL ramp_monotone_slot%0d: got %06h after %06h, required non-decreasing", k, last_outp[1], prev);
      end
      prev = last_outp[1];
    end
  endtask

  task automatic test_saturate();
    for (int ch = 0; ch < N_CH; ch++) lvl[0][ch] = 8'd128;
    set_words(24'h200000, 24'h200000, 24'h200000, 24'h200000);
    run_slot(24);
    run_slot(24);
    n_cmp++;
    if (last_outp[0] !== 24'h7FFFFF || last_sat[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_positive: got %06h sat=%b, required 7fffff sat=1", last_outp[0], last_sat[0]);
    end
    set_words(24'h800000, 24'h800000, 24'h800000, 24'h800000);
    run_slot(24);
    n_cmp += 2;
    if (last_outp[0] !== 24'h800000 || last_sat[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_negative: got %06h sat=%b, required 800000 sat=1", last_outp[0], last_sat[0]);
    end
    if (last_outp[1] !== 24'h800000 || last_sat[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL min_no_clip: got %06h sat=%b, required 800000 sat=0", last_outp[1], last_sat[1]);
    end
    set_words(24'h0, 24'h0, 24'h0, 24'h0);
    run_slot(24);
    n_cmp++;
    if (last_sat[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_clear: got sat=%b, required 0", last_sat[0]);
    end
  endtask

  task automatic test_mute();
    logic [23:0] exp_v;
    int g;
    set_words(24'h100000, 24'h0, 24'h0, 24'h0);
    mt[2][0] = 1'b1;
    for (int m = 1; m <= 33; m++) begin
      run_slot(24);
      g = 128 - 4 * (m - 1);
      exp_v = 24'(g * 32'h2000);
      n_cmp++;
      if (last_outp[2] !== exp_v) begin
        n_bad++;
        $display("FAIL mute_down_slot%0d: got %06h, required %06h", m, last_outp[2], exp_v);
      end
    end
    mt[2][0] = 1'b0;
    for (int m = 1; m <= 34; m++) begin
      run_slot(24);
      g = (4 * (m - 1) < 128) ? 4 * (m - 1) : 128;
      exp_v = 24'(g * 32'h2000);
      n_cmp++;
      if (last_outp[2] !== exp_v) begin
        n_bad++;
        $display("FAIL unmute_up_slot%0d: got %06h, required %06h", m, last_outp[2], exp_v);
      end
    end
  endtask

  task automatic test_short_slot();
    set_words(24'hABCDE0, 24'h0, 24'h0, 24'h0);
    run_slot(20);
    n_cmp++;
    if (last_outp[0] !== 24'hABCDE0 || last_sat[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL short_slot: got %06h sat=%b, required abcde0 sat=0", last_outp[0], last_sat[0]);
    end
    set_words(24'h0, 24'h0, 24'h0, 24'h0);
    run_slot(24);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (tx_cap[d] !== 24'hABCDE0) begin
        n_bad++;
        $display("FAIL serial_out dut%0d: got %06h, required abcde0", d, tx_cap[d]);
      end
    end
  endtask

  task automatic test_reset_mid_mac();
    bit seen;
    set_words(24'h100000, 24'h0, 24'h0, 24'h0);
    send_bits(24);
    @(negedge clk);
    lrclk = ~lrclk;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < N_DUT; d++) begin
      n_cmp++;
      if ({out_w[d], valid_w[d], sat_w[d], outp_w[d]} !== 27'h0) begin
        n_bad++;
        $display("FAIL mid_mac_reset dut%0d: got out=%b valid=%b sat=%b out_p=%06h, required all 0",
                 d, out_w[d], valid_w[d], sat_w[d], outp_w[d]);
      end
      for (int ch = 0; ch < N_CH; ch++) mg[d][ch] = 0;
    end
    sb_q.delete();
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (valid_w != '0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL mid_mac_no_valid: got out_valid after reset, required none");
    end
    run_slot(24);
    for (int d = 0; d < N_DUT; d++) begin
      n_cmp++;
      if (last_outp[d] !== 24'h0) begin
        n_bad++;
        $display("FAIL post_reset_slot dut%0d: got %06h, required 000000", d, last_outp[d]);
      end
    end
  endtask

  initial begin
    for (int d = 0; d < N_DUT; d++) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        lvl[d][ch] = 8'd0;
        mt[d][ch]  = 1'b0;
      end
      last_outp[d] = 24'h0;
      last_sat[d]  = 1'b0;
      tx_cap[d]    = 24'h0;
    end
    set_words(24'h0, 24'h0, 24'h0, 24'h0);
    test_reset();
    test_unity();
    test_ramp_up();
    test_saturate();
    test_mute();
    test_short_slot();
    test_reset_mid_mac();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
